// File: rtl/tdc_evfifo_pkg.sv
// tdc_evfifo_pkg
//   Shared definitions for the TDC event FIFO CSR slave. This file holds the
//   register word offsets within the bank (csr_a[2:0]), the STAT/CTRL bit
//   positions, and the helper that computes the effective IRQ threshold.
//   The RTL and the testbench both use these definitions.
package tdc_evfifo_pkg;

  typedef enum logic [2:0] {
    REG_STAT = 3'd0,
    REG_TS   = 3'd1,
    REG_CHAN = 3'd2,
    REG_POP  = 3'd3,
    REG_CTRL = 3'd4,
    REG_OVF  = 3'd5
  } reg_off_e;

  localparam int STAT_EMPTY_BIT  = 16;
  localparam int STAT_FULL_BIT   = 17;
  localparam int STAT_OVF_BIT    = 18;
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_THRESH_LSB = 8;

  // A programmed threshold of 0 would assert the IRQ while the FIFO is
  // empty. To avoid that, a threshold of 0 is treated the same as 1.
  function automatic logic [7:0] eff_thresh(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/tdc_evfifo_if.sv
// tdc_evfifo_if
//   CSR bus between csrbrg and its slaves.
//   csr_a  : 14-bit word address; bits [13:10] select the bank
//   csr_we : write strobe
//   csr_di : write data (from the bridge)
//   csr_do : registered read data (from the slave; 0 when not selected)
interface tdc_evfifo_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input csr_do);
  modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/tdc_evfifo_mem.sv
// tdc_evfifo_mem
//   Event storage for the FIFO. It is a dual-port RAM with a synchronous
//   write port and a synchronous read port. It also keeps a registered copy
//   of the current head entry.
//   sys_clk, sys_rst_n     : clock and synchronous active-low reset
//   wr_en/wr_addr/wr_data  : write port, used for pushes
//   head_from_wr           : load the head register from wr_data
//   head_from_rd           : load the head register from ram[rd_addr]
//   rd_addr                : address of the entry that follows the head
//   head                   : current head entry {chan, ts}
module tdc_evfifo_mem #(
  parameter int depth_log2 = 5,
  parameter int width      = 36
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_en,
  input  logic [depth_log2-1:0] wr_addr,
  input  logic [width-1:0]      wr_data,
  input  logic                  head_from_wr,
  input  logic                  head_from_rd,
  input  logic [depth_log2-1:0] rd_addr,
  output logic [width-1:0]      head
);

  logic [width-1:0] ram [2**depth_log2];

  always_ff @(posedge sys_clk) begin
    if (wr_en)
      ram[wr_addr] <= wr_data;
  end

  // The write path has priority for the head register. It covers two cases:
  // a push into an empty FIFO, and a push+pop at level 1. In both cases the
  // new head is the word being written on this edge, and it is not yet
  // readable from the RAM.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      head <= '0;
    else if (head_from_wr)
      head <= wr_data;
    else if (head_from_rd)
      head <= ram[rd_addr];
  end

endmodule

// File: rtl/tdc_evfifo.sv
// tdc_evfifo
//   CSR-bus slave that buffers TDC timestamp events (channel + 32-bit
//   timestamp). The CPU reads the head entry and pops it through the CSR
//   bus. A level IRQ is raised when the fill level reaches the programmed
//   threshold.
//   sys_clk, sys_rst_n : clock and synchronous active-low reset
//   csr                : CSR bus (slave side); csr_do is registered
//   ev_stb             : one-cycle event strobe
//   ev_chan, ev_ts     : event channel and timestamp, sampled with ev_stb
//   irq                : registered level interrupt
module tdc_evfifo
  import tdc_evfifo_pkg::*;
#(
  parameter logic [3:0] csr_addr   = 4'h2,
  parameter int         depth_log2 = 5,
  parameter int         chan_w     = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  tdc_evfifo_if.slave       csr,
  input  logic              ev_stb,
  input  logic [chan_w-1:0] ev_chan,
  input  logic [31:0]       ev_ts,
  output logic              irq
);

  localparam int PW = depth_log2 + 1;
  localparam int EW = chan_w + 32;

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, level;
  logic          empty, full, sel, do_pop, do_push, drop, ovf_clr, ctrl_wr;
  logic          irq_en, ovf_sticky;
  logic [7:0]    thresh;
  logic [15:0]   ovf_cnt;
  logic [EW-1:0] head;
  logic [31:0]   rd_data;
  reg_off_e      off;
  logic          unused_bits;

  // Full and empty both compare the two pointers. The extra MSB tells
  // whether the write pointer is one lap ahead of the read pointer.
  assign level      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  assign sel     = (csr.csr_a[13:10] == csr_addr);
  assign off     = reg_off_e'(csr.csr_a[2:0]);
  assign ovf_clr = sel & csr.csr_we & (off == REG_OVF);
  assign ctrl_wr = sel & csr.csr_we & (off == REG_CTRL);

  // A pop frees a slot on the same edge. For that reason a strobe that
  // arrives while the FIFO is full is accepted whenever it coincides with
  // a pop.
  assign do_pop  = sel & csr.csr_we & (off == REG_POP) & ~empty;
  assign do_push = ev_stb & (~full | do_pop);
  assign drop    = ev_stb & full & ~do_pop;

  assign unused_bits = ^{csr.csr_a[9:3], csr.csr_di[31:16], csr.csr_di[7:1],
                         rd_ptr_nxt[PW-1]};

  tdc_evfifo_mem #(
    .depth_log2 (depth_log2),
    .width      (EW)
  ) u_mem (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .wr_en        (do_push),
    .wr_addr      (wr_ptr[PW-2:0]),
    .wr_data      ({ev_chan, ev_ts}),
    .head_from_wr (do_push & (empty | (do_pop & (level == PW'(1))))),
    .head_from_rd (do_pop),
    .rd_addr      (rd_ptr_nxt[PW-2:0]),
    .head         (head)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
    end
  end

  // If a clear and a drop happen on the same edge, the clear wins. This way
  // the CPU never sees a stale sticky bit right after acknowledging it.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ovf_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end else if (ovf_clr) begin
      ovf_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      irq_en <= 1'b0;
      thresh <= 8'd1;
    end else if (ctrl_wr) begin
      irq_en <= csr.csr_di[CTRL_EN_BIT];
      thresh <= csr.csr_di[CTRL_THRESH_LSB +: 8];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      irq <= 1'b0;
    else
      irq <= irq_en & (16'(level) >= 16'(eff_thresh(thresh)));
  end

  // The read mux always looks at the state before the current edge. If a
  // write and a read of the same register happen in one cycle, the read
  // returns the old value.
  always_comb begin
    rd_data = '0;
    case (off)
      REG_STAT: begin
        rd_data[15:0]          = 16'(level);
        rd_data[STAT_EMPTY_BIT] = empty;
        rd_data[STAT_FULL_BIT]  = full;
        rd_data[STAT_OVF_BIT]   = ovf_sticky;
      end
      REG_TS:   rd_data = empty ? 32'd0 : head[31:0];
      REG_CHAN: rd_data = empty ? 32'd0 : 32'(head[EW-1:32]);
      REG_CTRL: rd_data = {16'd0, thresh, 7'd0, irq_en};
      REG_OVF:  rd_data = {16'd0, ovf_cnt};
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      csr.csr_do <= '0;
    else
      csr.csr_do <= sel ? rd_data : 32'd0;
  end

endmodule

// File: tb/tb_tdc_evfifo.sv
// tb_tdc_evfifo
//   Randomized, scoreboard-checked bench for tdc_evfifo. The reference model
//   keeps the FIFO as a queue of events and applies the documented rules
//   once per clock edge. Every CSR access pushes its expected read word onto
//   a queue. A separate monitor pops that queue and compares it with csr_do
//   one cycle later, and it also checks irq on every cycle.
module tb_tdc_evfifo;
  import tdc_evfifo_pkg::*;

  localparam int DEPTH = 32;

  typedef struct packed {
    logic [3:0]  chan;
    logic [31:0] ts;
  } ev_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        ev_stb = 1'b0;
  logic [3:0]  ev_chan = '0;
  logic [31:0] ev_ts = '0;
  logic        irq;

  tdc_evfifo_if bus();

  tdc_evfifo #(
    .csr_addr   (4'h2),
    .depth_log2 (5),
    .chan_w     (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csr       (bus),
    .ev_stb    (ev_stb),
    .ev_chan   (ev_chan),
    .ev_ts     (ev_ts),
    .irq       (irq)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state
  ev_t         mq[$];
  int          m_ovf = 0;
  bit          m_sticky = 1'b0;
  bit          m_en = 1'b0;
  int          m_thr = 1;
  bit          m_irq = 1'b0;

  // Scoreboard
  logic [31:0] exp_val[$];
  int          exp_addr[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  bit          mon_en = 1'b0;
  logic        rd_strobe = 1'b0;
  logic        rd_seen = 1'b0;

  initial begin
    bus.csr_a  = '0;
    bus.csr_we = 1'b0;
    bus.csr_di = '0;
  end

  function automatic string reg_name(input int a);
    case (a)
      0: return "STAT";
      1: return "TS";
      2: return "CHAN";
      3: return "POP";
      4: return "CTRL";
      5: return "OVF";
      default: return "RSVD";
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      0: begin
        v[15:0] = 16'(mq.size());
        v[16]   = (mq.size() == 0);
        v[17]   = (mq.size() == DEPTH);
        v[18]   = m_sticky;
      end
      1: v = (mq.size() == 0) ? 32'd0 : mq[0].ts;
      2: v = (mq.size() == 0) ? 32'd0 : {28'd0, mq[0].chan};
      4: v = {16'd0, 8'(m_thr), 7'd0, m_en};
      5: v = 32'(m_ovf);
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock of stimulus. Read expectations come from the model before the
  // edge. The model state advances only after the edge, so the monitor
  // always sees the model value that matches the DUT's registered outputs.
  task automatic applyStimulus(input bit stb, input logic [3:0] ch,
                               input logic [31:0] ts, input logic [3:0] bank,
                               input bit we, input int addr,
                               input logic [31:0] di);
    bit sel, pop, nirq, in_reset;
    int thr_eff;
    sel = (bank == 4'h2);
    in_reset = !sys_rst_n;
    ev_stb     = stb;
    ev_chan    = ch;
    ev_ts      = ts;
    bus.csr_a  = {bank, 7'd0, 3'(addr)};
    bus.csr_we = we;
    bus.csr_di = di;
    rd_strobe  = sel;
    if (sel) begin
      exp_val.push_back(in_reset ? 32'd0 : model_read(addr));
      exp_addr.push_back(addr);
    end
    thr_eff = (m_thr == 0) ? 1 : m_thr;
    nirq = m_en && (mq.size() >= thr_eff);
    pop  = sel && we && (addr == 3) && (mq.size() > 0);
    @(posedge sys_clk);
    #1;
    if (in_reset) begin
      mq.delete();
      m_ovf = 0; m_sticky = 1'b0; m_en = 1'b0; m_thr = 1; m_irq = 1'b0;
    end else begin
      m_irq = nirq;
      if (stb && !(mq.size() == DEPTH && !pop)) begin
        if (pop) void'(mq.pop_front());
        mq.push_back('{chan: ch, ts: ts});
      end else begin
        if (pop) void'(mq.pop_front());
        if (stb) begin
          m_sticky = 1'b1;
          if (m_ovf < 65535) m_ovf++;
        end
      end
      if (sel && we && addr == 5) begin
        m_ovf = 0;
        m_sticky = 1'b0;
      end
      if (sel && we && addr == 4) begin
        m_en  = di[0];
        m_thr = int'(di[15:8]);
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 32'd0, 4'h0, 1'b0, 0, 32'd0);
  endtask

  task automatic push(input logic [3:0] ch, input logic [31:0] ts);
    applyStimulus(1'b1, ch, ts, 4'h0, 1'b0, 0, 32'd0);
  endtask

  task automatic csr_rd(input int a);
    applyStimulus(1'b0, 4'd0, 32'd0, 4'h2, 1'b0, a, 32'd0);
  endtask

  task automatic csr_wr(input int a, input logic [31:0] d);
    applyStimulus(1'b0, 4'd0, 32'd0, 4'h2, 1'b1, a, d);
  endtask

  task automatic do_reset(input bit stb);
    sys_rst_n = 1'b0;
    applyStimulus(stb, 4'd5, 32'hDEAD0000, 4'h0, 1'b0, 0, 32'd0);
    sys_rst_n = 1'b1;
  endtask

  always @(posedge sys_clk) rd_seen <= rd_strobe;

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (rd_seen) begin
        if (exp_val.size() == 0) begin
          checkOutput("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          checkOutput(reg_name(exp_addr.pop_front()), bus.csr_do,
                      exp_val.pop_front());
        end
      end else begin
        checkOutput("csr_do_deselected", bus.csr_do, 32'd0);
      end
      checkOutput("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  bank, ch;
    logic [31:0] ts, di;
    bit          stb, we;
    int          r, addr;

    // Reset state
    do_reset(1'b0);
    mon_en = 1'b1;
    csr_rd(0);
    csr_rd(1);
    csr_rd(4);
    csr_rd(5);

    // Single push, head readback, pop back to empty
    push(4'd3, 32'h12345678);
    csr_rd(1);
    csr_rd(2);
    csr_rd(0);
    csr_wr(3, 32'd0);
    csr_rd(0);
    csr_wr(3, 32'd0);
    csr_rd(0);

    // Fill to depth, overflow by three, clear the overflow
    for (int i = 0; i < DEPTH + 3; i++) push(4'(i), 32'hA000_0000 + i);
    csr_rd(0);
    csr_rd(5);
    csr_rd(1);
    csr_wr(5, 32'd0);
    csr_rd(5);
    csr_rd(0);

    // Push and pop together while full
    applyStimulus(1'b1, 4'hE, 32'hBEEF0001, 4'h2, 1'b1, 3, 32'd0);
    csr_rd(0);
    csr_rd(5);
    csr_rd(1);
    csr_rd(2);

    // Overflow and clear on the same edge
    applyStimulus(1'b1, 4'h1, 32'h0, 4'h2, 1'b1, 5, 32'd0);
    csr_rd(5);
    csr_rd(0);

    // IRQ threshold 4
    do_reset(1'b0);
    csr_wr(4, 32'h0000_0401);
    for (int i = 0; i < 3; i++) push(4'(i), 32'h100 + i);
    idle();
    idle();
    push(4'd7, 32'h200);
    idle();
    idle();
    csr_wr(3, 32'd0);
    idle();
    idle();
    csr_rd(4);

    // Push and pop together at level 1, then while empty
    do_reset(1'b0);
    push(4'd9, 32'h55);
    applyStimulus(1'b1, 4'hA, 32'h66, 4'h2, 1'b1, 3, 32'd0);
    csr_rd(1);
    csr_rd(2);
    csr_wr(3, 32'd0);
    applyStimulus(1'b1, 4'hB, 32'h77, 4'h2, 1'b1, 3, 32'd0);
    csr_rd(0);
    csr_rd(1);

    // Reset in the middle of a burst at level 10
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) push(4'(i), 32'h300 + i);
    do_reset(1'b1);
    csr_rd(0);
    csr_rd(5);
    csr_rd(4);
    csr_rd(1);

    // Randomized traffic: a fill-heavy phase, then a drain-heavy phase
    csr_wr(4, {16'd0, 8'($urandom_range(0, 40)), 7'd0, 1'b1});
    for (int i = 0; i < 900; i++) begin
      r    = $urandom_range(0, 99);
      stb  = ($urandom_range(0, 99) < ((i < 450) ? 70 : 20));
      ch   = 4'($urandom);
      ts   = $urandom;
      bank = 4'h0;
      we   = 1'b0;
      addr = 0;
      di   = 32'd0;
      if (r < 30) begin
        bank = 4'h2; addr = $urandom_range(0, 7);
      end else if (r < (i < 450 ? 38 : 70)) begin
        bank = 4'h2; we = 1'b1; addr = 3;
      end else if (r < 73) begin
        bank = 4'h2; we = 1'b1; addr = 5;
      end else if (r < 76) begin
        bank = 4'h2; we = 1'b1; addr = 4;
        di = {16'd0, 8'($urandom_range(0, 40)), 7'd0, 1'($urandom)};
      end else if (r < 80) begin
        bank = 4'($urandom_range(0, 15));
        if (bank == 4'h2) bank = 4'h3;
        we = 1'b1; addr = $urandom_range(0, 7); di = $urandom;
      end else if (r < 83) begin
        bank = 4'h2; we = 1'b1; addr = $urandom_range(6, 7); di = $urandom;
      end
      if (i == 700) do_reset(stb);
      else applyStimulus(stb, ch, ts, bank, we, addr, di);
    end

    idle();
    idle();
    checkOutput("scoreboard_drained", 32'(exp_val.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
